// File: rtl/station_aggregator.sv
// Collects per-station percentage_stored reports over one frame and publishes network totals R and G.
// Optional watchdog enabled by defining AGG_TIMEOUT_EN.
module station_aggregator #(
   parameter int MAX_STATIONS   = 16,
   parameter int ID_W           = 8,
   parameter int INT            = 31,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            frame_start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ID_W-1:0] in_station_id,
   input  logic [INT:0]    in_percentage,
   input  logic            in_last,
   output logic [INT:0]    total_percentage_stored,
   output logic [INT:0]    number_of_stations,
   output logic            out_valid,
   output logic            dup_error,
   output logic            empty_frame,
   output logic            timeout
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_PUBLISH = 2'd2;
   localparam int BM_W = (MAX_STATIONS > 1) ? $clog2(MAX_STATIONS) : 1;
   localparam logic [ID_W:0] ID_LIMIT = (ID_W+1)'(MAX_STATIONS);

   function automatic logic [INT:0] sat_add(input logic [INT:0] a, input logic [INT:0] b);
      logic [INT+1:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[INT+1]) begin
         sat_add = {(INT+1){1'b1}};
      end else begin
         sat_add = sum[INT:0];
      end
   endfunction

   logic [1:0]              state_r;
   logic                    in_ready_r;
   logic [INT:0]            acc_r;
   logic [INT:0]            count_r;
   logic [MAX_STATIONS-1:0] seen_r;
   logic [INT:0]            r_r;
   logic [INT:0]            g_r;
   logic                    out_valid_r;
   logic                    dup_error_r;
   logic                    empty_frame_r;
   logic                    timeout_r;

   logic [1:0]              state_s;
   logic [INT:0]            acc_s;
   logic [INT:0]            count_s;
   logic [MAX_STATIONS-1:0] seen_s;
   logic [INT:0]            r_s;
   logic [INT:0]            g_s;
   logic                    out_valid_s;
   logic                    dup_error_s;
   logic                    empty_frame_s;
   logic                    timeout_s;
   logic                    clear_s;
   logic                    accept_s;
   logic                    drop_s;
   logic [BM_W-1:0]         idx_s;
   logic                    wd_fire_s;

   assign accept_s = in_valid && in_ready_r;
   assign idx_s    = in_station_id[BM_W-1:0];
   assign drop_s   = ({1'b0, in_station_id} >= ID_LIMIT) || seen_r[idx_s];

`ifdef AGG_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_r;

   // Watchdog counts consecutive COLLECT cycles without an accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_r <= '0;
      end else if ((state_r != ST_COLLECT) || frame_start || accept_s) begin
         wd_r <= '0;
      end else begin
         wd_r <= wd_r + WD_W'(1);
      end
   end

   assign wd_fire_s = (state_r == ST_COLLECT) && !frame_start && !accept_s &&
                      (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic timeout_unused_s;
   assign timeout_unused_s = (TIMEOUT_CYCLES == 0);
   assign wd_fire_s        = 1'b0;
`endif

   // Next-state and datapath updates for the frame controller.
   always_comb begin
      state_s       = state_r;
      acc_s         = acc_r;
      count_s       = count_r;
      seen_s        = seen_r;
      r_s           = r_r;
      g_s           = g_r;
      dup_error_s   = dup_error_r;
      timeout_s     = timeout_r;
      out_valid_s   = 1'b0;
      empty_frame_s = 1'b0;
      clear_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (frame_start) begin
               state_s = ST_COLLECT;
               clear_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (frame_start) begin
               state_s = ST_COLLECT;
               clear_s = 1'b1;
            end else if (accept_s) begin
               if (drop_s) begin
                  dup_error_s = 1'b1;
               end else begin
                  acc_s         = sat_add(acc_r, in_percentage);
                  count_s       = count_r + (INT+1)'(1);
                  seen_s[idx_s] = 1'b1;
               end
               if (in_last) begin
                  state_s = ST_PUBLISH;
               end else begin
                  state_s = ST_COLLECT;
               end
            end else if (wd_fire_s) begin
               state_s   = ST_PUBLISH;
               timeout_s = 1'b1;
            end else begin
               state_s = ST_COLLECT;
            end
         end
         ST_PUBLISH: begin
            if (count_r != '0) begin
               r_s         = acc_r;
               g_s         = count_r;
               out_valid_s = 1'b1;
            end else begin
               empty_frame_s = 1'b1;
            end
            if (frame_start) begin
               state_s = ST_COLLECT;
               clear_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      // Frame entry (including abort) wipes all per-frame state; any beat this cycle is lost.
      if (clear_s) begin
         acc_s       = '0;
         count_s     = '0;
         seen_s      = '0;
         dup_error_s = 1'b0;
         timeout_s   = 1'b0;
      end else begin
         state_s = state_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         in_ready_r    <= 1'b0;
         acc_r         <= '0;
         count_r       <= '0;
         seen_r        <= '0;
         r_r           <= '0;
         g_r           <= (INT+1)'(1);
         out_valid_r   <= 1'b0;
         dup_error_r   <= 1'b0;
         empty_frame_r <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         in_ready_r    <= (state_s == ST_COLLECT);
         acc_r         <= acc_s;
         count_r       <= count_s;
         seen_r        <= seen_s;
         r_r           <= r_s;
         g_r           <= g_s;
         out_valid_r   <= out_valid_s;
         dup_error_r   <= dup_error_s;
         empty_frame_r <= empty_frame_s;
         timeout_r     <= timeout_s;
      end
   end

   assign in_ready                = in_ready_r;
   assign total_percentage_stored = r_r;
   assign number_of_stations      = g_r;
   assign out_valid               = out_valid_r;
   assign dup_error               = dup_error_r;
   assign empty_frame             = empty_frame_r;
   assign timeout                 = timeout_r;

endmodule

// File: doc/station_aggregator.md
# station_aggregator

Collects the per-station `percentage_stored` reports from every dropoff station on one resource network and publishes the network totals `total_percentage_stored` (R) and `number_of_stations` (G). It sits directly upstream of each `dropoff_train_station` and drives that block's R and G inputs. Reports arrive as a time-multiplexed valid/ready stream, one frame per balancing round. Results are held stable between frames so downstream divisions never see a partial sum or a zero divisor.

## Interface
Parameters:
- `MAX_STATIONS`, 16: number of distinct station IDs accepted per frame. Maximum 256.
- `ID_W`, 8: width of the station ID field.
- `INT`, 31: MSB index of all data words.
- `TIMEOUT_CYCLES`, 1024: watchdog limit. Used only when `AGG_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `frame_start`, in, 1: one-cycle pulse that opens a new collection frame.
- `in_valid`, in, 1: report beat present.
- `in_ready`, out, 1: the block accepts the beat this cycle.
- `in_station_id`, in, `ID_W`: ID of the reporting station.
- `in_percentage`, in, `INT+1`: that station's `percentage_stored` (S).
- `in_last`, in, 1: final beat of the frame.
- `total_percentage_stored`, out, `INT+1`: published R.
- `number_of_stations`, out, `INT+1`: published G. Never 0.
- `out_valid`, out, 1: one-cycle pulse when R and G have just updated.
- `dup_error`, out, 1: sticky flag. A beat was dropped this frame because its ID was duplicate or out of range.
- `empty_frame`, out, 1: one-cycle pulse when a frame closed with zero accepted reports.
- `timeout`, out, 1: sticky flag. The frame was closed by the watchdog. Tied 0 when `AGG_TIMEOUT_EN` is undefined.

## Operation
The state machine has three states: IDLE, COLLECT, PUBLISH.

IDLE:
- `in_ready`=0.
- `frame_start` moves to COLLECT. On the same edge: accumulator=0, count=0, seen-bitmap=0, `dup_error`=0, `timeout`=0.

COLLECT:
- `in_ready`=1. A beat is accepted when `in_valid && in_ready`.
- If `in_station_id >= MAX_STATIONS`, or its bitmap bit is already set: drop the beat and set `dup_error`.
- Otherwise:
  - accumulator += `in_percentage`, saturating at 2^(INT+1)-1;
  - count += 1;
  - set the ID's bitmap bit.
- An accepted beat with `in_last`=1 moves to PUBLISH, whether the beat was counted or dropped. The last beat's contribution is included.
- `frame_start` in COLLECT aborts the frame: everything is cleared as on entry and the machine stays in COLLECT. A beat accepted in that same cycle is discarded.

PUBLISH (always exactly one cycle):
- `in_ready`=0.
- If count>0: load R=accumulator and G=count, and pulse `out_valid`.
- If count=0: R and G keep their previous values, there is no `out_valid`, and `empty_frame` pulses.
- Next state is COLLECT if `frame_start` is high in this cycle (with the entry clears), otherwise IDLE.

Arithmetic:
- Unsigned throughout.
- The count cannot exceed `MAX_STATIONS`, so it needs no saturation.

## Timing
- Reset values:
  - state=IDLE;
  - `in_ready`=0;
  - `total_percentage_stored`=0;
  - `number_of_stations`=1;
  - `out_valid`=0, `dup_error`=0, `empty_frame`=0, `timeout`=0;
  - accumulator, count and bitmap = 0.
- `in_ready` is a registered function of state only. It never depends on `in_valid`.
- A `frame_start` sampled at edge k gives `in_ready`=1 after edge k.
- A last beat accepted at edge k puts the machine in PUBLISH after edge k. At edge k+1, R and G update and `out_valid` (or `empty_frame`) is high for the cycle that follows. Latency is 2 edges.
- R and G change only on the edge that raises `out_valid`.
- Reset asserted mid-frame returns to the reset values immediately. A partial frame is never published.
- Maximum throughput is one beat per cycle.

## Configuration
- `AGG_TIMEOUT_EN` defined:
  - A watchdog counter clears on COLLECT entry and on every accepted beat, and increments on every other COLLECT cycle.
  - When it reaches `TIMEOUT_CYCLES`, the machine goes to PUBLISH (publishing whatever was accumulated) and sets `timeout`.
- `AGG_TIMEOUT_EN` undefined:
  - No watchdog logic. `timeout` is tied 0.
  - COLLECT waits for `in_last` or `frame_start` indefinitely.

## Test plan
- **Basic frame.** Reset, then `frame_start`, then beats (id0,400), (id1,250), (id2,350, last). Expect `out_valid` 2 edges after the last beat, R=1000, G=3, `dup_error`=0.
- **Duplicate and out-of-range IDs.** Beats (id3,100), (id3,900), (id40,50, last) with `MAX_STATIONS`=16. Expect R=100, G=1, `dup_error`=1.
- **Empty frame.** `frame_start`, then a single beat with id99 and last. Expect no `out_valid`, `empty_frame` pulse, and R and G unchanged from the prior frame (0 and 1 after reset).
- **Saturation and back-pressure.** With `INT`=7, send beats 200 and 100 (last). Expect R=255, G=2. `in_valid` held high in IDLE must show `in_ready`=0 with no accumulation.
- **Abort and reset.** `frame_start` mid-COLLECT after (id0,500), then (id1,70, last): expect R=70, G=1. Separately, `rst_n` low mid-frame: expect reset values immediately and no `out_valid`.
- **Watchdog (with `AGG_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8).** One beat (id0,300), then silence. Expect PUBLISH after 8 idle cycles, R=300, G=1, `timeout`=1.
